// File: rtl/i2c_target.sv
// I2C target (slave) responder.
//
// Oversamples the open-drain SCL/SDA lines in the clk_i domain, decodes START, repeated
// START and STOP, acknowledges its own 7-bit address, hands written bytes to local logic
// and serves read bytes from local logic. SDA is only ever pulled low via sda_oe_o.
//
// Ports:
//   clk_i       system clock
//   rst_ni      asynchronous active-low reset
//   scl_i       raw SCL from the bus
//   sda_i       raw SDA from the bus
//   sda_oe_o    1 = pull SDA low, 0 = release
//   rx_data_o   last byte received in a write transfer
//   rx_valid_o  one-cycle pulse, rx_data_o newly valid
//   tx_data_i   byte returned on the next read byte
//   tx_req_o    one-cycle pulse in the cycle tx_data_i is loaded
//   rw_o        R/W bit of the current addressed transfer (1 = read)
//   busy_o      high from any START until STOP
//   done_o      one-cycle pulse on STOP when this target was addressed
//   state_o     current FSM state (debug)
module i2c_target #(
    parameter logic [6:0] Addr = 7'b1010101
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic [7:0] tx_data_i,
    output logic       tx_req_o,
    output logic       rw_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StAddr     = 3'd1,
        StAckAddr  = 3'd2,
        StRxByte   = 3'd3,
        StAckRx    = 3'd4,
        StTxByte   = 3'd5,
        StAckTx    = 3'd6,
        StWaitStop = 3'd7
    } state_e;

    // Two synchronizer stages plus one history stage per line; idle bus is high.
    logic scl_s1_q, scl_s2_q, scl_h_q;
    logic sda_s1_q, sda_s2_q, sda_h_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
            scl_h_q  <= 1'b1;
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
            sda_h_q  <= 1'b1;
        end else begin
            scl_s1_q <= scl_i;
            scl_s2_q <= scl_s1_q;
            scl_h_q  <= scl_s2_q;
            sda_s1_q <= sda_i;
            sda_s2_q <= sda_s1_q;
            sda_h_q  <= sda_s2_q;
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  = scl_s2_q & ~scl_h_q;
    assign scl_fall  = ~scl_s2_q & scl_h_q;
    // SDA edges only count while SCL is high in both samples.
    assign start_det = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
    assign stop_det  = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rw_q, rw_d;
    logic       oe_q, oe_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_req_q, tx_req_d;
    logic       done_q, done_d;
    logic       busy_q, busy_d;
    logic       match_q, match_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        rw_d       = rw_q;
        oe_d       = oe_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        done_d     = 1'b0;
        busy_d     = busy_q;
        match_d    = match_q;

        if (stop_det) begin
            state_d = StIdle;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = match_q;
            match_d = 1'b0;
        end else if (start_det) begin
            state_d = StAddr;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
            busy_d  = 1'b1;
            match_d = 1'b0;
        end else begin
            unique case (state_q)
                StAddr: begin
                    if (scl_rise && cnt_q < 4'd8) begin
                        shift_d = {shift_q[6:0], sda_s2_q};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        if (shift_q[7:1] == Addr) begin
                            state_d = StAckAddr;
                            oe_d    = 1'b1;
                            rw_d    = shift_q[0];
                            match_d = 1'b1;
                        end else begin
                            state_d = StWaitStop;
                            oe_d    = 1'b0;
                        end
                    end
                end
                StAckAddr: begin
                    if (scl_fall) begin
                        cnt_d = 4'd0;
                        if (rw_q) begin
                            state_d  = StTxByte;
                            shift_d  = tx_data_i;
                            tx_req_d = 1'b1;
                            oe_d     = ~tx_data_i[7];
                        end else begin
                            state_d = StRxByte;
                            oe_d    = 1'b0;
                        end
                    end
                end
                StRxByte: begin
                    if (scl_rise && cnt_q < 4'd8) begin
                        shift_d = {shift_q[6:0], sda_s2_q};
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            rx_data_d  = {shift_q[6:0], sda_s2_q};
                            rx_valid_d = 1'b1;
                        end
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        state_d = StAckRx;
                        oe_d    = 1'b1;
                    end
                end
                StAckRx: begin
                    if (scl_fall) begin
                        state_d = StRxByte;
                        oe_d    = 1'b0;
                        cnt_d   = 4'd0;
                    end
                end
                StTxByte: begin
                    // Bit 7 went out on entry; falls 1..7 send bits 6..0, fall 8 releases.
                    if (scl_fall) begin
                        if (cnt_q == 4'd7) begin
                            state_d = StAckTx;
                            oe_d    = 1'b0;
                        end else begin
                            oe_d    = ~shift_q[6];
                            shift_d = {shift_q[6:0], 1'b0};
                            cnt_d   = cnt_q + 4'd1;
                        end
                    end
                end
                StAckTx: begin
                    if (scl_rise && sda_s2_q) begin
                        state_d = StWaitStop;
                    end else if (scl_fall) begin
                        state_d  = StTxByte;
                        shift_d  = tx_data_i;
                        tx_req_d = 1'b1;
                        oe_d     = ~tx_data_i[7];
                        cnt_d    = 4'd0;
                    end
                end
                StWaitStop: oe_d = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            shift_q    <= 8'd0;
            rx_data_q  <= 8'd0;
            rw_q       <= 1'b0;
            oe_q       <= 1'b0;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            match_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rw_q       <= rw_d;
            oe_q       <= oe_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            match_q    <= match_d;
        end
    end

    assign sda_oe_o   = oe_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign tx_req_o   = tx_req_q;
    assign rw_o       = rw_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a behavioural bus master drives SCL/SDA with 10-clk
// phases and the open-drain line is modelled as a wired AND of master and target.
module tb_i2c_target;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       m_sda = 1'b1;
    logic [7:0] tx_data = 8'hCB;

    logic       sda_oe, rx_valid, tx_req, rw, busy, done;
    logic [7:0] rx_data;
    logic [2:0] state;
    logic       sda_line;

    assign sda_line = m_sda & ~sda_oe;

    i2c_target dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .scl_i      (scl),
        .sda_i      (sda_line),
        .sda_oe_o   (sda_oe),
        .rx_data_o  (rx_data),
        .rx_valid_o (rx_valid),
        .tx_data_i  (tx_data),
        .tx_req_o   (tx_req),
        .rw_o       (rw),
        .busy_o     (busy),
        .done_o     (done),
        .state_o    (state)
    );

    always #5 clk = ~clk;

    // Pulse monitors: count high cycles so a stretched pulse shows up as extra counts.
    int rx_cnt = 0;
    int tx_cnt = 0;
    int done_cnt = 0;
    always @(posedge clk) begin
        if (rx_valid) rx_cnt <= rx_cnt + 1;
        if (tx_req) tx_cnt <= tx_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_c();
        m_sda = 1'b1;
        wait_clk(5);
        scl = 1'b1;
        wait_clk(10);
        m_sda = 1'b0;
        wait_clk(10);
        scl = 1'b0;
        wait_clk(5);
    endtask

    task automatic stop_c();
        m_sda = 1'b0;
        wait_clk(5);
        scl = 1'b1;
        wait_clk(10);
        m_sda = 1'b1;
        wait_clk(10);
    endtask

    // One SCL period; seen is the wired line sampled mid-high.
    task automatic clock_bit(input logic b, output logic seen);
        m_sda = b;
        wait_clk(5);
        scl = 1'b1;
        wait_clk(5);
        seen = sda_line;
        wait_clk(5);
        scl = 1'b0;
        wait_clk(5);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(d[i], s);
        clock_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic m_ack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            d[i] = s;
        end
        clock_bit(~m_ack, s);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic       ack, s;
        logic [7:0] d;
        int         rx0, tx0, dn0;

        // Reset hold with idle bus.
        wait_clk(5);
        check_eq("rst_oe", sda_oe, 0);
        check_eq("rst_state", state, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_rw", rw, 0);
        check_eq("rst_rxdata", rx_data, 0);
        check_eq("rst_pulses", {rx_valid, tx_req, done}, 0);
        rst_n = 1'b1;
        wait_clk(5);

        // Write three bytes of 0xCB to 0x55.
        rx0 = rx_cnt; dn0 = done_cnt;
        start_c();
        check_eq("w_busy", busy, 1);
        check_eq("w_state_addr", state, 1);
        write_byte(8'hAA, ack);
        check_eq("w_addr_ack", ack, 1);
        for (int k = 0; k < 3; k++) begin
            write_byte(8'hCB, ack);
            check_eq("w_data_ack", ack, 1);
            check_eq("w_rxdata", rx_data, 8'hCB);
            check_eq("w_rxcnt", rx_cnt - rx0, k + 1);
        end
        check_eq("w_rw", rw, 0);
        stop_c();
        check_eq("w_done", done_cnt - dn0, 1);
        check_eq("w_busy_end", busy, 0);
        check_eq("w_state_end", state, 0);

        // Write to foreign address 0x2A.
        rx0 = rx_cnt; dn0 = done_cnt;
        start_c();
        write_byte(8'h54, ack);
        check_eq("f_addr_nack", ack, 0);
        check_eq("f_state", state, 7);
        write_byte(8'h12, ack);
        check_eq("f_data_nack", ack, 0);
        check_eq("f_state2", state, 7);
        stop_c();
        check_eq("f_state_end", state, 0);
        check_eq("f_rxcnt", rx_cnt - rx0, 0);
        check_eq("f_done", done_cnt - dn0, 0);

        // Read three bytes from 0x55, NACK the last.
        tx0 = tx_cnt; dn0 = done_cnt;
        start_c();
        write_byte(8'hAB, ack);
        check_eq("r_addr_ack", ack, 1);
        check_eq("r_rw", rw, 1);
        read_byte(1'b1, d);
        check_eq("r_byte0", d, 8'hCB);
        read_byte(1'b1, d);
        check_eq("r_byte1", d, 8'hCB);
        read_byte(1'b0, d);
        check_eq("r_byte2", d, 8'hCB);
        check_eq("r_released", sda_oe, 0);
        check_eq("r_state_wait", state, 7);
        check_eq("r_txreq", tx_cnt - tx0, 3);
        stop_c();
        check_eq("r_done", done_cnt - dn0, 1);

        // Repeated START after four data bits of a write, then a read.
        rx0 = rx_cnt; tx0 = tx_cnt; dn0 = done_cnt;
        start_c();
        write_byte(8'hAA, ack);
        check_eq("rs_addr_ack", ack, 1);
        clock_bit(1'b1, s);
        clock_bit(1'b0, s);
        clock_bit(1'b1, s);
        clock_bit(1'b0, s);
        start_c();
        check_eq("rs_state", state, 1);
        check_eq("rs_rxcnt", rx_cnt - rx0, 0);
        write_byte(8'hAB, ack);
        check_eq("rs_rd_ack", ack, 1);
        read_byte(1'b0, d);
        check_eq("rs_rd_byte", d, 8'hCB);
        check_eq("rs_txreq", tx_cnt - tx0, 1);
        stop_c();
        check_eq("rs_done", done_cnt - dn0, 1);

        // Reset while the target drives a 0 data bit (third bit of 0xCB).
        start_c();
        write_byte(8'hAB, ack);
        check_eq("ar_addr_ack", ack, 1);
        clock_bit(1'b1, s);
        clock_bit(1'b1, s);
        m_sda = 1'b1;
        wait_clk(5);
        scl = 1'b1;
        wait_clk(5);
        check_eq("ar_driving", sda_oe, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("ar_oe_async", sda_oe, 0);
        check_eq("ar_state", state, 0);
        wait_clk(5);
        rst_n = 1'b1;
        wait_clk(5);
        dn0 = done_cnt;
        start_c();
        write_byte(8'hAA, ack);
        check_eq("ar_new_ack", ack, 1);
        write_byte(8'h3C, ack);
        check_eq("ar_data_ack", ack, 1);
        check_eq("ar_rxdata", rx_data, 8'h3C);
        stop_c();
        check_eq("ar_done", done_cnt - dn0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
